// File: rtl/id_x_stage_reg.sv
// ID->X pipeline register: captures decoded fields, inserts bubbles, applies flushes,
// holds on memory stalls and keeps perf counters. Optional macro: LOAD_USE_STALL_EN.
module id_x_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_ID,
  input  logic [XLEN-1:0]  pc_ID,
  input  logic [XLEN-1:0]  inst_ID,
  input  logic [6:0]       opcode_ID,
  input  logic [4:0]       rd_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rf_wen_ID,
  input  logic [XLEN-1:0]  rs1_data_ID,
  input  logic [XLEN-1:0]  rs2_data_ID,
  input  logic             stall_mem,
  input  logic             flush_X,
  output logic             valid_X,
  output logic [XLEN-1:0]  pc_X,
  output logic [XLEN-1:0]  inst_X,
  output logic [6:0]       opcode_X,
  output logic [4:0]       rd_X,
  output logic [4:0]       rs1_X,
  output logic [4:0]       rs2_X,
  output logic             rf_wen_X,
  output logic [XLEN-1:0]  rs1_data_X,
  output logic [XLEN-1:0]  rs2_data_X,
  output logic             stall_ID,
  output logic [1:0]       state_X,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);
  localparam logic [6:0]      OP_NOP   = 7'h13;
  localparam logic [6:0]      OP_LOAD  = 7'h03;

  state_t state;
  logic   flush_pend;
  logic   flush_any;
  logic   load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign flush_any = flush_X | flush_pend;

`ifdef LOAD_USE_STALL_EN
  assign load_use = valid_X & rf_wen_X & (opcode_X == OP_LOAD) & (rd_X != 5'd0) &
                    valid_ID & ((rd_X == rs1_ID) | (rd_X == rs2_ID));
`else
  assign load_use = 1'b0;
`endif

  // A flush kills the ID instruction upstream, so it never needs to be held.
  assign stall_ID = stall_mem | (load_use & ~flush_any);
  assign state_X  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_X    <= 1'b0;
      pc_X       <= '0;
      inst_X     <= NOP_INST;
      opcode_X   <= OP_NOP;
      rd_X       <= '0;
      rs1_X      <= '0;
      rs2_X      <= '0;
      rf_wen_X   <= 1'b0;
      rs1_data_X <= '0;
      rs2_data_X <= '0;
      state      <= RUN;
      flush_pend <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (stall_mem) begin
      state     <= HOLD;
      stall_cnt <= sat_inc(stall_cnt);
      if (flush_X) flush_pend <= 1'b1;
    end else if (flush_any) begin
      valid_X    <= 1'b0;
      inst_X     <= NOP_INST;
      opcode_X   <= OP_NOP;
      rd_X       <= '0;
      rf_wen_X   <= 1'b0;
      flush_pend <= 1'b0;
      flush_cnt  <= sat_inc(flush_cnt);
      state      <= RUN;
    end else if (load_use) begin
      valid_X  <= 1'b0;
      inst_X   <= NOP_INST;
      opcode_X <= OP_NOP;
      rd_X     <= '0;
      rf_wen_X <= 1'b0;
      state    <= BUBBLE;
    end else begin
      valid_X    <= valid_ID;
      pc_X       <= pc_ID;
      inst_X     <= inst_ID;
      opcode_X   <= opcode_ID;
      rd_X       <= rd_ID;
      rs1_X      <= rs1_ID;
      rs2_X      <= rs2_ID;
      rf_wen_X   <= rf_wen_ID;
      rs1_data_X <= rs1_data_ID;
      rs2_data_X <= rs2_data_ID;
      state      <= RUN;
    end
  end

`ifdef LOAD_USE_STALL_EN
  // Counts only bubbles actually inserted; a same-cycle flush takes precedence.
  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (!stall_mem && !flush_any && load_use)
      bubble_cnt <= sat_inc(bubble_cnt);
  end
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_x_stage_reg.sv
// Bench for id_x_stage_reg: directed pipeline scenarios followed by random traffic,
// all compared against a rule-level reference model of the X stage.
module tb_id_x_stage_reg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_ID;
  logic [XLEN-1:0]  pc_ID, inst_ID, rs1_data_ID, rs2_data_ID;
  logic [6:0]       opcode_ID;
  logic [4:0]       rd_ID, rs1_ID, rs2_ID;
  logic             rf_wen_ID, stall_mem, flush_X;
  logic             valid_X, rf_wen_X, stall_ID;
  logic [XLEN-1:0]  pc_X, inst_X, rs1_data_X, rs2_data_X;
  logic [6:0]       opcode_X;
  logic [4:0]       rd_X, rs1_X, rs2_X;
  logic [1:0]       state_X;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  id_x_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID), .pc_ID(pc_ID), .inst_ID(inst_ID),
    .opcode_ID(opcode_ID), .rd_ID(rd_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rf_wen_ID(rf_wen_ID), .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .stall_mem(stall_mem), .flush_X(flush_X), .valid_X(valid_X), .pc_X(pc_X),
    .inst_X(inst_X), .opcode_X(opcode_X), .rd_X(rd_X), .rs1_X(rs1_X), .rs2_X(rs2_X),
    .rf_wen_X(rf_wen_X), .rs1_data_X(rs1_data_X), .rs2_data_X(rs2_data_X),
    .stall_ID(stall_ID), .state_X(state_X), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model of what sits in X, plus pending flush, state and counters
  bit        m_valid, m_wen, m_pend;
  bit [31:0] m_pc, m_inst, m_d1, m_d2;
  bit [6:0]  m_op;
  bit [4:0]  m_rd, m_rs1, m_rs2;
  int        m_state, m_stall, m_bub, m_flush;

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  function automatic bit hazard();
`ifdef LOAD_USE_STALL_EN
    return m_valid && m_wen && m_op == 7'h03 && m_rd != 0 && valid_ID &&
           (m_rd == rs1_ID || m_rd == rs2_ID);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_stall_id();
    return stall_mem || (hazard() && !(flush_X || m_pend));
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_wen = 0; m_rd = 0; m_inst = 32'h13; m_op = 7'h13;
  endtask

  task automatic model_edge();
    bit haz, fl;
    haz = hazard();
    fl  = flush_X || m_pend;
    if (!rst_n) begin
      m_valid = 0; m_wen = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_pc = 0;
      m_d1 = 0; m_d2 = 0; m_inst = 32'h13; m_op = 7'h13; m_pend = 0;
      m_state = 0; m_stall = 0; m_bub = 0; m_flush = 0;
    end else if (stall_mem) begin
      m_state = 1;
      m_stall = sat(m_stall);
      if (flush_X) m_pend = 1;
    end else if (fl) begin
      model_bubble();
      m_pend = 0; m_flush = sat(m_flush); m_state = 0;
    end else if (haz) begin
      model_bubble();
      m_bub = sat(m_bub); m_state = 2;
    end else begin
      m_valid = valid_ID; m_pc = pc_ID; m_inst = inst_ID; m_op = opcode_ID;
      m_rd = rd_ID; m_rs1 = rs1_ID; m_rs2 = rs2_ID; m_wen = rf_wen_ID;
      m_d1 = rs1_data_ID; m_d2 = rs2_data_ID; m_state = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_id(input bit v, input bit [31:0] pc, input bit [6:0] op,
                          input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit wen);
    valid_ID = v; pc_ID = pc; opcode_ID = op; rd_ID = rd; rs1_ID = rs1; rs2_ID = rs2;
    rf_wen_ID = wen;
    inst_ID = {7'h0, rs2, rs1, 3'h0, rd, op};
    rs1_data_ID = $urandom; rs2_data_ID = $urandom;
  endtask

  task automatic drive_rand_id();
    bit [6:0] ops [5];
    ops[0] = 7'h03; ops[1] = 7'h33; ops[2] = 7'h13; ops[3] = 7'h23; ops[4] = 7'h63;
    drive_id($urandom_range(0, 3) != 0, $urandom, ops[$urandom_range(0, 4)],
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    inst_ID = $urandom;
  endtask

  task automatic ctl(input bit r, input bit sm, input bit fx);
    rst_n = r; stall_mem = sm; flush_X = fx;
  endtask

  // One clock: check combinational stall, advance model, check all registered outputs
  task automatic step();
    #1;
    chk("stall_ID", stall_ID, exp_stall_id());
    model_edge();
    @(posedge clk);
    #1;
    chk("valid_X", valid_X, m_valid);
    chk("pc_X", pc_X, m_pc);
    chk("inst_X", inst_X, m_inst);
    chk("opcode_X", opcode_X, m_op);
    chk("rd_X", rd_X, m_rd);
    chk("rs1_X", rs1_X, m_rs1);
    chk("rs2_X", rs2_X, m_rs2);
    chk("rf_wen_X", rf_wen_X, m_wen);
    chk("rs1_data_X", rs1_data_X, m_d1);
    chk("rs2_data_X", rs2_data_X, m_d2);
    chk("state_X", state_X, m_state);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bub);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  initial begin
    // Reset, even with stall and flush asserted
    drive_rand_id();
    ctl(0, 1, 1); step();
    ctl(0, 0, 0); step();
    chk("rst_inst", inst_X, 64'h13);
    chk("rst_opcode", opcode_X, 64'h13);
    chk("rst_valid", valid_X, 64'h0);

    // Three back-to-back ADDs
    ctl(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_id(1, 32'(i * 4), 7'h33, 5'(i + 1), 5'd1, 5'd2, 1);
      step();
      chk("add_pc_X", pc_X, 64'(i * 4));
      chk("add_state", state_X, 64'h0);
      chk("add_stall_id", stall_ID, 64'h0);
    end

    // LW x5 then dependent ADD x6,x5,x1 (held by upstream while stalled)
    drive_id(1, 32'h10, 7'h03, 5'd5, 5'd2, 5'd0, 1); step();
    drive_id(1, 32'h14, 7'h33, 5'd6, 5'd5, 5'd1, 1);
`ifdef LOAD_USE_STALL_EN
    #1 chk("lu_stall_id", stall_ID, 64'h1);
    step();
    chk("lu_bubble_valid", valid_X, 64'h0);
    chk("lu_bubble_inst", inst_X, 64'h13);
    chk("lu_bubble_cnt", bubble_cnt, 64'h1);
    chk("lu_state", state_X, 64'h2);
`endif
    step();
    chk("lu_add_pc", pc_X, 64'h14);
    // Same with x0 destination: never interlocks
    drive_id(1, 32'h18, 7'h03, 5'd0, 5'd2, 5'd0, 1); step();
    drive_id(1, 32'h1c, 7'h33, 5'd6, 5'd0, 5'd0, 1);
    #1 chk("x0_stall_id", stall_ID, 64'h0);
    step();

    // Memory stall for 4 cycles with ADD in X
    drive_id(1, 32'h20, 7'h33, 5'd7, 5'd1, 5'd2, 1); step();
    drive_id(1, 32'h24, 7'h33, 5'd8, 5'd1, 5'd2, 1);
    ctl(1, 1, 0);
    for (int i = 0; i < 4; i++) step();
    chk("hold_pc", pc_X, 64'h20);
    chk("hold_state", state_X, 64'h1);
    chk("hold_stall_cnt", stall_cnt, 64'h4);
    ctl(1, 0, 0); step();
    chk("release_pc", pc_X, 64'h24);

    // Flush during a stall, applied on release
    ctl(1, 1, 1); step();
    ctl(1, 1, 0); step();
    chk("pend_hold_valid", valid_X, 64'h1);
    ctl(1, 0, 0); step();
    chk("pend_bubble_valid", valid_X, 64'h0);
    chk("pend_flush_cnt", flush_cnt, 64'h1);

    // Flush and load-use in the same cycle
    drive_id(1, 32'h30, 7'h03, 5'd7, 5'd1, 5'd0, 1); step();
    drive_id(1, 32'h34, 7'h33, 5'd9, 5'd7, 5'd1, 1);
    ctl(1, 0, 1);
    #1 chk("fl_lu_stall_id", stall_ID, 64'h0);
    step();
    chk("fl_lu_flush_cnt", flush_cnt, 64'h2);
    chk("fl_lu_bubble_cnt", bubble_cnt, 64'(m_bub));

    // Reset during HOLD with pending flush: no bubble after reset
    drive_id(1, 32'h40, 7'h33, 5'd3, 5'd1, 5'd2, 1); ctl(1, 0, 0); step();
    ctl(1, 1, 1); step();
    ctl(0, 1, 0); step();
    drive_id(1, 32'h44, 7'h33, 5'd4, 5'd1, 5'd2, 1);
    ctl(1, 0, 0); step();
    chk("post_rst_valid", valid_X, 64'h1);
    chk("post_rst_flush_cnt", flush_cnt, 64'h0);

    // Saturation
    ctl(1, 1, 0);
    for (int i = 0; i < CMAX + 4; i++) step();
    chk("sat_stall_cnt", stall_cnt, 64'(CMAX));
    ctl(1, 0, 1);
    for (int i = 0; i < CMAX + 4; i++) step();
    chk("sat_flush_cnt", flush_cnt, 64'(CMAX));
    ctl(1, 0, 0);
    for (int i = 0; i < CMAX + 4; i++) begin
      drive_id(1, 32'h100, 7'h03, 5'd5, 5'd1, 5'd0, 1); step();
      drive_id(1, 32'h104, 7'h33, 5'd6, 5'd5, 5'd1, 1); step();
      if (valid_X == 1'b0) step();
    end
`ifdef LOAD_USE_STALL_EN
    chk("sat_bubble_cnt", bubble_cnt, 64'(CMAX));
`else
    chk("tied_bubble_cnt", bubble_cnt, 64'h0);
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive_rand_id();
      ctl($urandom_range(0, 99) != 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_x_stage_reg.md
Name: id_x_stage_reg

Overview:
- ID→X pipeline register of the 3-stage core (IF/ID, X, WB); captures decoded fields and operands that the X-stage datapath and the forwarding logic consume (rd_X, rs1_X, rs2_X, rf_wen_X, opcode_X).
- Owns X-stage bubble insertion, branch-flush kill and memory-stall hold, and drives stall_ID back to fetch/decode.
- Keeps saturating stall/bubble/flush event counters for CSR perf readout.

Parameters:
- XLEN, 32, datapath width of PC, instruction and operands.
- CNT_W, 16, width of each perf counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- valid_ID  in  1  ID holds a real instruction.
- pc_ID  in  XLEN  PC of ID instruction.
- inst_ID  in  XLEN  raw instruction.
- opcode_ID  in  7  decoded opcode.
- rd_ID, rs1_ID, rs2_ID  in  5 each  register specifiers.
- rf_wen_ID  in  1  instruction writes the register file.
- rs1_data_ID, rs2_data_ID  in  XLEN  operands after ID forwarding mux.
- stall_mem  in  1  memory not ready; freeze the X stage.
- flush_X  in  1  taken branch/jump resolved in X; kill the younger instruction.
- valid_X, pc_X, inst_X, opcode_X, rd_X, rs1_X, rs2_X, rf_wen_X, rs1_data_X, rs2_data_X  out  (widths as ID)  registered X-stage fields.
- stall_ID  out  1  combinational; upstream must hold IF/ID this cycle.
- state_X  out  2  FSM state: 0 RUN, 1 HOLD, 2 BUBBLE.
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  perf counters.

Behaviour:
- Reset (rst_n=0 at edge) sets:
  - valid_X=0, rf_wen_X=0, rd/rs1/rs2_X=0, pc_X=0, data_X=0.
  - inst_X=32'h0000_0013 (NOP), opcode_X=7'h13.
  - state=RUN, flush_pend=0, all counters=0.
  - Reset overrides every other input, including mid-stall and mid-bubble.
- Bubble load: valid_X=0, rf_wen_X=0, rd_X=0, inst_X=NOP, opcode_X=7'h13. pc_X and data_X are don't-care and are held.
- Per-edge priority (highest first): reset; stall_mem; flush (flush_X | flush_pend); load-use; normal capture.
- stall_mem=1:
  - All X registers hold. state→HOLD. stall_ID=1. stall_cnt+1.
  - If flush_X=1 in the same cycle, set flush_pend=1.
- Flush (no stall_mem):
  - Load bubble, clear flush_pend, flush_cnt+1 (once per flush event, pending or direct). state→RUN.
  - stall_ID=0, because the ID instruction is wrong-path and is killed upstream.
- Load-use condition (LOAD_USE_STALL_EN only): valid_X & rf_wen_X & opcode_X==7'h03 & rd_X!=0 & valid_ID & (rd_X==rs1_ID | rd_X==rs2_ID).
  - Response: stall_ID=1, load bubble, bubble_cnt+1, state→BUBBLE.
  - Next cycle X holds a bubble, so the condition clears: exactly one bubble per dependency.
- Normal capture: all ID fields are registered; valid_X=valid_ID; state→RUN.
- Latency: 1 cycle ID→X when not stalled.
- HOLD→RUN on the first edge with stall_mem=0. A pending flush is applied on that same edge.
- Counters saturate at all-ones. There is no wrap.
- x0 destination never triggers an interlock.

Optional Feature:
- Macro: LOAD_USE_STALL_EN.
- Defined: load-use interlock as above. The BUBBLE state is reachable.
- Undefined: no interlock logic. stall_ID=stall_mem. bubble_cnt is tied to 0. The BUBBLE state is never entered. Load-use hazards rely on WB→X forwarding.

Test Plan:
- Reset then 3 back-to-back ADDs (pc 0x0,0x4,0x8) → each appears on pc_X one cycle later, valid_X=1, stall_ID=0, state_X=0.
- LW x5 in X, ID ADD x6,x5,x1 (EN) → stall_ID=1 for one cycle; X gets bubble (valid_X=0, inst_X=0x13); ADD enters X the next cycle; bubble_cnt=1. Same case with rd=x0 → no stall.
- stall_mem high for 4 cycles with ADD in X → X fields unchanged, state_X=1, stall_cnt=4; release → next ID instruction captured.
- flush_X pulse with stall_mem=1, stall_mem released 2 cycles later → X holds during the stall, then gets a bubble on the release edge; flush_cnt=1.
- flush_X and load-use in the same cycle → bubble loaded, stall_ID=0, flush_cnt+1, bubble_cnt unchanged.
- rst_n low during HOLD with flush_pend=1 → all outputs at reset values, flush_pend cleared, no bubble applied after reset; counters preloaded near max then exercised → stay at all-ones.
